// File: rtl/program_loader_if.sv
// Bundle of the loader's byte-stream input and its instruction-memory/core-control outputs.
// The slave modport faces the loader; the master modport faces the stream source and observers.
interface program_loader_if #(
    parameter int ADDR_LENGTH  = 12,
    parameter int INSTR_LENGTH = 19
);
    logic                    rx_valid;
    logic [7:0]              rx_data;
    logic                    rx_ready;
    logic                    imem_we;
    logic [ADDR_LENGTH-1:0]  imem_addr;
    logic [INSTR_LENGTH-1:0] imem_wdata;
    logic                    core_rst;
    logic                    load_done;
    logic                    load_error;

    modport master (
        output rx_valid, rx_data,
        input  rx_ready, imem_we, imem_addr, imem_wdata, core_rst, load_done, load_error
    );

    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, imem_we, imem_addr, imem_wdata, core_rst, load_done, load_error
    );
endinterface

// File: rtl/program_loader.sv
// Boot loader: parses a framed byte stream (A5, count, 3 bytes/word, checksum), writes words
// to instruction memory from address 0 and releases the core only after a good checksum.
module program_loader #(
    parameter int ADDR_LENGTH  = 12,
    parameter int INSTR_LENGTH = 19
) (
    input  logic             clk,
    input  logic             rst,
    program_loader_if.slave  bus
);
    localparam int MAX_WORDS = 1 << ADDR_LENGTH;

    typedef enum logic [2:0] {
        S_SYNC, S_CNT_HI, S_CNT_LO, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERROR
    } state_t;

    state_t                  r_state, w_state_next;
    logic [7:0]              r_count_hi, w_count_hi_next;
    logic [ADDR_LENGTH:0]    r_count, w_count_next;
    logic [ADDR_LENGTH:0]    r_word_cnt, w_word_cnt_next;
    logic [INSTR_LENGTH-1:0] r_word, w_word_next;
    logic [1:0]              r_byte_idx, w_byte_idx_next;
    logic [7:0]              r_sum, w_sum_next;

    logic                    w_rx_ready;
    logic                    w_accept;
    logic [15:0]             w_count;
    logic [7:0]              w_sum_acc;
    logic [ADDR_LENGTH:0]    w_word_cnt_inc;

    // rx_ready is a pure state decode so it never depends on rx_valid
    assign w_rx_ready = (r_state == S_SYNC)   || (r_state == S_CNT_HI) ||
                        (r_state == S_CNT_LO) || (r_state == S_DATA)   ||
                        (r_state == S_CHECK);
    assign w_accept       = bus.rx_valid & w_rx_ready;
    assign w_count        = {r_count_hi, bus.rx_data};
    assign w_sum_acc      = r_sum + bus.rx_data;
    assign w_word_cnt_inc = r_word_cnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_SYNC;
            r_count_hi <= '0;
            r_count    <= '0;
            r_word_cnt <= '0;
            r_word     <= '0;
            r_byte_idx <= '0;
            r_sum      <= '0;
        end else begin
            r_state    <= w_state_next;
            r_count_hi <= w_count_hi_next;
            r_count    <= w_count_next;
            r_word_cnt <= w_word_cnt_next;
            r_word     <= w_word_next;
            r_byte_idx <= w_byte_idx_next;
            r_sum      <= w_sum_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_count_hi_next  = r_count_hi;
        w_count_next     = r_count;
        w_word_cnt_next  = r_word_cnt;
        w_word_next      = r_word;
        w_byte_idx_next  = r_byte_idx;
        w_sum_next       = r_sum;
        case (r_state)
            S_SYNC: begin
                if (w_accept && bus.rx_data == 8'hA5) w_state_next = S_CNT_HI;
            end
            S_CNT_HI: begin
                if (w_accept) begin
                    w_sum_next      = bus.rx_data;
                    w_count_hi_next = bus.rx_data;
                    w_state_next    = S_CNT_LO;
                end
            end
            S_CNT_LO: begin
                if (w_accept) begin
                    w_sum_next      = w_sum_acc;
                    w_word_cnt_next = '0;
                    w_byte_idx_next = '0;
                    if (w_count == 16'd0 || 32'(w_count) > MAX_WORDS) begin
                        w_state_next = S_ERROR;
                    end else begin
                        w_count_next = w_count[ADDR_LENGTH:0];
                        w_state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_accept) begin
                    w_sum_next = w_sum_acc;
                    // After three shifts only B0[2:0], B1 and B2 remain in the word
                    w_word_next = {r_word[INSTR_LENGTH-9:0], bus.rx_data};
                    if (r_byte_idx == 2'd2) begin
                        w_byte_idx_next = '0;
                        w_state_next    = S_WRITE;
                    end else begin
                        w_byte_idx_next = r_byte_idx + 2'd1;
                    end
                end
            end
            S_WRITE: begin
                w_word_cnt_next = w_word_cnt_inc;
                w_state_next    = (w_word_cnt_inc == r_count) ? S_CHECK : S_DATA;
            end
            S_CHECK: begin
                if (w_accept) begin
                    w_sum_next   = w_sum_acc;
                    w_state_next = (w_sum_acc == 8'h00) ? S_DONE : S_ERROR;
                end
            end
            S_DONE:  w_state_next = S_DONE;
            S_ERROR: w_state_next = S_ERROR;
            default: w_state_next = S_SYNC;
        endcase
    end

    assign bus.rx_ready   = w_rx_ready;
    assign bus.imem_we    = (r_state == S_WRITE);
    assign bus.imem_addr  = r_word_cnt[ADDR_LENGTH-1:0];
    assign bus.imem_wdata = r_word;
    assign bus.core_rst   = (r_state != S_DONE);
    assign bus.load_done  = (r_state == S_DONE);
    assign bus.load_error = (r_state == S_ERROR);
endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: frames are driven byte by byte and every write strobe
// is captured into a shadow memory that is compared against hand-computed words.
module tb_program_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;

    program_loader_if #(.ADDR_LENGTH(12), .INSTR_LENGTH(19)) bus ();

    program_loader #(.ADDR_LENGTH(12), .INSTR_LENGTH(19)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [18:0] cap_mem [4096];
    int          n_writes;
    logic [11:0] first_addr;
    logic [11:0] last_addr;

    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            cap_mem[bus.imem_addr] = bus.imem_wdata;
            if (n_writes == 0) first_addr = bus.imem_addr;
            last_addr = bus.imem_addr;
            n_writes++;
            $display("write addr=%03h data=%05h", bus.imem_addr, bus.imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_capture();
        for (int i = 0; i < 4096; i++) cap_mem[i] = 19'h7FFFF;
        n_writes   = 0;
        first_addr = 12'hFFF;
        last_addr  = 12'h000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_capture();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        bus.rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        waited = 0;
        while (bus.rx_ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (bus.rx_ready !== 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout observed=rx_ready_low expected=accept byte=%02h", b);
            bus.rx_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        $display("byte %02h accepted", b);
    endtask

    // N=2 frame: words 0x51234 and 0x0ABCD; CHK only sent when send_chk is set
    task automatic send_frame_n2(input logic [7:0] chk, input bit send_chk, input int gapmax);
        logic [7:0] fr [8];
        fr = '{8'hA5, 8'h00, 8'h02, 8'h05, 8'h12, 8'h34, 8'h00, 8'hAB};
        for (int i = 0; i < 8; i++) send_byte(fr[i], (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
        send_byte(8'hCD, (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
        if (send_chk) send_byte(chk, (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
    endtask

    initial begin
        logic [7:0] sum;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        clear_capture();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_rx_ready",   32'(bus.rx_ready),   32'h1);
        check("rst_imem_we",    32'(bus.imem_we),    32'h0);
        check("rst_imem_addr",  32'(bus.imem_addr),  32'h0);
        check("rst_imem_wdata", 32'(bus.imem_wdata), 32'h0);
        check("rst_core_rst",   32'(bus.core_rst),   32'h1);
        check("rst_load_done",  32'(bus.load_done),  32'h0);
        check("rst_load_error", 32'(bus.load_error), 32'h0);

        // Good N=2 load, release on the CHK-accept edge
        send_frame_n2(8'h3B, 1'b0, 0);
        @(negedge clk); #1;
        check("t1_core_rst_pre",  32'(bus.core_rst),  32'h1);
        check("t1_load_done_pre", 32'(bus.load_done), 32'h0);
        send_byte(8'h3B, 0);
        check("t1_core_rst_edge",  32'(bus.core_rst),  32'h0);
        check("t1_load_done_edge", 32'(bus.load_done), 32'h1);
        @(negedge clk); #1;
        check("t1_writes", 32'(n_writes),   32'd2);
        check("t1_mem0",   32'(cap_mem[0]), 32'h51234);
        check("t1_mem1",   32'(cap_mem[1]), 32'h0ABCD);
        check("t1_rx_ready", 32'(bus.rx_ready),   32'h0);
        check("t1_error",    32'(bus.load_error), 32'h0);

        // Bad checksum
        do_reset();
        send_frame_n2(8'h3C, 1'b1, 0);
        @(negedge clk); #1;
        check("t2_writes",   32'(n_writes),       32'd2);
        check("t2_mem1",     32'(cap_mem[1]),     32'h0ABCD);
        check("t2_error",    32'(bus.load_error), 32'h1);
        check("t2_done",     32'(bus.load_done),  32'h0);
        check("t2_core_rst", 32'(bus.core_rst),   32'h1);
        check("t2_rx_ready", 32'(bus.rx_ready),   32'h0);

        // Garbage before sync plus random stalls
        do_reset();
        send_byte(8'h11, 2);
        send_byte(8'h22, 1);
        send_frame_n2(8'h3B, 1'b1, 5);
        @(negedge clk); #1;
        check("t3_writes",   32'(n_writes),      32'd2);
        check("t3_mem0",     32'(cap_mem[0]),    32'h51234);
        check("t3_mem1",     32'(cap_mem[1]),    32'h0ABCD);
        check("t3_done",     32'(bus.load_done), 32'h1);
        check("t3_core_rst", 32'(bus.core_rst),  32'h0);

        // Illegal counts
        do_reset();
        send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        @(negedge clk); #1;
        check("t4a_error",    32'(bus.load_error), 32'h1);
        check("t4a_rx_ready", 32'(bus.rx_ready),   32'h0);
        repeat (4) @(negedge clk);
        #1;
        check("t4a_writes",   32'(n_writes),       32'd0);
        do_reset();
        send_byte(8'hA5, 0); send_byte(8'h10, 0); send_byte(8'h01, 0);
        @(negedge clk); #1;
        check("t4b_error",    32'(bus.load_error), 32'h1);
        repeat (4) @(negedge clk);
        #1;
        check("t4b_writes",   32'(n_writes),       32'd0);
        check("t4b_core_rst", 32'(bus.core_rst),   32'h1);

        // Maximum N=4096 with word i = i
        do_reset();
        send_byte(8'hA5, 0); send_byte(8'h10, 0); send_byte(8'h00, 0);
        sum = 8'h10;
        for (int i = 0; i < 4096; i++) begin
            logic [15:0] w;
            w = 16'(i);
            send_byte(8'h00, 0);
            send_byte(w[15:8], 0);
            send_byte(w[7:0], 0);
            sum = sum + w[15:8] + w[7:0];
        end
        send_byte(8'h00 - sum, 0);
        @(negedge clk); #1;
        check("t5_writes",     32'(n_writes),      32'd4096);
        check("t5_first_addr", 32'(first_addr),    32'h000);
        check("t5_last_addr",  32'(last_addr),     32'hFFF);
        check("t5_mem0",       32'(cap_mem[0]),    32'h00000);
        check("t5_mem2748",    32'(cap_mem[2748]), 32'h00ABC);
        check("t5_mem4095",    32'(cap_mem[4095]), 32'h00FFF);
        check("t5_done",       32'(bus.load_done), 32'h1);

        // Reset mid-load, then a full reload
        do_reset();
        send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h02, 0);
        send_byte(8'h05, 0); send_byte(8'h12, 0); send_byte(8'h34, 0);
        @(negedge clk);
        check("t6_we_latency", 32'(bus.imem_we),   32'h1);
        check("t6_we_addr",    32'(bus.imem_addr), 32'h0);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_we",       32'(bus.imem_we),   32'h0);
        check("t6_async_rx_ready", 32'(bus.rx_ready),  32'h1);
        check("t6_async_core_rst", 32'(bus.core_rst),  32'h1);
        check("t6_async_wdata",    32'(bus.imem_wdata), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        clear_capture();
        send_frame_n2(8'h3B, 1'b1, 0);
        @(negedge clk); #1;
        check("t6_first_addr", 32'(first_addr),    32'h000);
        check("t6_writes",     32'(n_writes),      32'd2);
        check("t6_mem0",       32'(cap_mem[0]),    32'h51234);
        check("t6_mem1",       32'(cap_mem[1]),    32'h0ABCD);
        check("t6_done",       32'(bus.load_done), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/program_loader.md
# program_loader

Boot-time loader upstream of the processor's instruction memory and PC. After reset it holds the core in reset, receives a framed byte stream over a valid/ready interface, assembles 19-bit instruction words, and writes them to consecutive instruction-memory addresses from 0. It verifies a checksum, then releases the core so it starts fetching at PC 0.

## Interface
- ADDR_LENGTH, 12, instruction-memory address width (matches PC width)
- INSTR_LENGTH, 19, instruction width
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- rx_valid  in  1  byte available on rx_data
- rx_data  in  8  stream byte
- rx_ready  out  1  loader accepts byte this cycle (transfer = rx_valid & rx_ready at rising clk)
- imem_we  out  1  one-cycle instruction-memory write strobe
- imem_addr  out  ADDR_LENGTH  write address
- imem_wdata  out  INSTR_LENGTH  write data
- core_rst  out  1  reset to PC/register file/flags; high until load succeeds
- load_done  out  1  sticky, load completed with good checksum
- load_error  out  1  sticky, bad length or checksum

## Operation
- Frame: 0xA5 sync, COUNT_HI, COUNT_LO (16-bit word count N, big-endian), N×3 data bytes, CHK.
- Word bytes: B0[2:0] -> instr[18:16] (B0[7:3] ignored), B1 -> instr[15:8], B2 -> instr[7:0].
- Checksum: 8-bit sum mod 256 of COUNT_HI, COUNT_LO, all data bytes and CHK must equal 0x00. Sync byte excluded.
- Legal N: 1..2^ADDR_LENGTH (1..4096). N = 0 or N > 4096 -> ERROR immediately after COUNT_LO accepted.
- States:
  - SYNC: rx_ready=1. Non-0xA5 bytes discarded. 0xA5 -> CNT_HI.
  - CNT_HI -> CNT_LO: one byte each. Running sum starts at the COUNT_HI byte.
  - CNT_LO: on accept, check N -> DATA or ERROR.
  - DATA: byte index 0..2, shift into word register. Third byte -> WRITE.
  - WRITE: one cycle, rx_ready=0, imem_we=1, imem_addr=word counter, imem_wdata=assembled word. Counter increments. Last word -> CHECK, else -> DATA.
  - CHECK: accept CHK. Sum==0 -> DONE, else ERROR.
  - DONE: terminal. rx_ready=0, core_rst=0, load_done=1.
  - ERROR: terminal. rx_ready=0, core_rst=1, load_error=1.
- Word counter is ADDR_LENGTH+1 bits, so N=4096 writes addresses 0..4095 with no wrap.
- Terminal states are left only by rst. The loader never loads again without reset.

## Timing
- Reset values: rx_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, core_rst=1, load_done=0, load_error=0, state SYNC, counters/sum 0.
- All outputs are registered or state-decoded. No combinational path from rx_valid/rx_data to any output.
- rx_ready does not depend on rx_valid. Stalls (rx_valid low) of any length are allowed in every receiving state.
- Write latency: imem_we is high in the cycle directly after the edge that accepted B2.
- Throughput: 4 cycles per word minimum (3 bytes + 1 write cycle).
- Release: the edge accepting a good CHK sets load_done=1 and core_rst=0. The core's first fetch of address 0 is the next edge.
- rst asserted mid-load: outputs return to reset values immediately (asynchronously). Partially written memory contents are don't-care. The next frame overwrites from address 0.

## Test plan
- Load N=2: A5 00 02 | 05 12 34 | 00 AB CD | CHK=(-(0x02+0x05+0x12+0x34+0xAB+0xCD)) mod 256 = 0x3B -> writes addr0=0x51234, addr1=0x0ABCD, load_done=1, core_rst falls on the CHK-accept edge.
- Same frame with CHK=0x3C -> both writes occur, load_error=1, core_rst stays 1, rx_ready=0.
- Garbage 11 22 before A5, plus random rx_valid gaps of 0–5 cycles -> identical writes and result as the first test, imem_we exactly 2 pulses.
- COUNT=0x0000 and COUNT=0x1001 -> load_error=1 after COUNT_LO, no imem_we pulse.
- N=4096 with incrementing words -> last write addr 0xFFF, no wrap to 0, load_done=1.
- Assert rst for 1 cycle after the first word is written, then send the full frame from the first test -> outputs reset asynchronously, reload starts at addr0, load_done=1.
